// File: rtl/qpsk_rx_framer.sv
// qpsk_rx_framer: receive-side framer for the QPSK demodulator.
// Generates the symbol-centre sampling strobe, hunts for the sync word,
// reads a one-byte length header and streams the payload bytes out on a
// valid/ready interface with start/done/error status pulses.
module qpsk_rx_framer #(
  parameter int unsigned SPS       = 4,
  parameter logic [15:0] SYNC_WORD = 16'hE4B1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] demod_sym,
  output logic       sample_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0] SPS_M1   = 8'(SPS - 1);
  localparam logic [3:0] HCNT_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_LEN     = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        sample_en_q;
  logic        take_q;
  logic [1:0]  sc_q, sc_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [15:0] sync_sr_q, sync_sr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  pk_q, pk_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  // Candidate values if the current symbol is consumed this cycle.
  logic [15:0] sync_new_s;
  logic [3:0]  hcnt_new_s;
  logic [7:0]  pk_new_s;
  logic [7:0]  len_new_s;
  logic        slot_free_s;

  assign sync_new_s  = {sync_sr_q[13:0], demod_sym};
  assign hcnt_new_s  = (hcnt_q == HCNT_MAX) ? HCNT_MAX : (hcnt_q + 4'd1);
  assign pk_new_s    = {pk_q[5:0], demod_sym};
  assign len_new_s   = {len_q[5:0], demod_sym};
  assign slot_free_s = (!m_valid_q) || m_ready;

  assign sample_en   = sample_en_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

  // Symbol-centre strobe: count 0..SPS-1, strobe after the terminal count,
  // and delay it one cycle to line up with the demodulator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 8'd0;
      sample_en_q <= 1'b0;
      take_q      <= 1'b0;
    end else begin
      take_q <= sample_en_q;
      if (!en) begin
        cnt_q       <= 8'd0;
        sample_en_q <= 1'b0;
      end else begin
        sample_en_q <= (cnt_q == SPS_M1);
        cnt_q       <= (cnt_q == SPS_M1) ? 8'd0 : (cnt_q + 8'd1);
      end
    end
  end

  // Framer next-state: sync hunt, length header, payload packing and the
  // single-entry output slot with overrun detection.
  always_comb begin
    state_d       = state_q;
    sc_d          = sc_q;
    hcnt_d        = hcnt_q;
    sync_sr_d     = sync_sr_q;
    len_d         = len_q;
    rem_d         = rem_q;
    pk_d          = pk_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q && !m_ready;
    m_last_d      = m_last_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;

    if (!en) begin
      // Disable abandons the frame silently; the output slot keeps draining.
      state_d   = ST_IDLE;
      sc_d      = 2'd0;
      hcnt_d    = 4'd0;
      sync_sr_d = 16'd0;
      rem_d     = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          hcnt_d  = 4'd0;
        end
        ST_HUNT: begin
          if (take_q) begin
            sync_sr_d = sync_new_s;
            hcnt_d    = hcnt_new_s;
            if ((sync_new_s == SYNC_WORD) && (hcnt_new_s == HCNT_MAX)) begin
              state_d       = ST_LEN;
              frame_start_d = 1'b1;
              sc_d          = 2'd0;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (take_q) begin
            len_d = len_new_s;
            sc_d  = sc_q + 2'd1;
            if (sc_q == 2'd3) begin
              if (len_new_s == 8'd0) begin
                frame_err_d = 1'b1;
                state_d     = ST_HUNT;
                hcnt_d      = 4'd0;
              end else begin
                rem_d   = len_new_s;
                state_d = ST_PAYLOAD;
              end
            end else begin
              state_d = ST_LEN;
            end
          end else begin
            state_d = ST_LEN;
          end
        end
        ST_PAYLOAD: begin
          if (take_q) begin
            pk_d = pk_new_s;
            sc_d = sc_q + 2'd1;
            if (sc_q == 2'd3) begin
              if (slot_free_s) begin
                m_data_d  = pk_new_s;
                m_valid_d = 1'b1;
                m_last_d  = (rem_q == 8'd1);
                rem_d     = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_HUNT;
                  hcnt_d       = 4'd0;
                end else begin
                  state_d = ST_PAYLOAD;
                end
              end else begin
                // Overrun: the held byte wins, the new byte is dropped.
                frame_err_d = 1'b1;
                state_d     = ST_HUNT;
                hcnt_d      = 4'd0;
              end
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_LEN) || (state_d == ST_PAYLOAD);
  end

  // Framer state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sc_q          <= 2'd0;
      hcnt_q        <= 4'd0;
      sync_sr_q     <= 16'd0;
      len_q         <= 8'd0;
      rem_q         <= 8'd0;
      pk_q          <= 8'd0;
      m_data_q      <= 8'd0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sc_q          <= sc_d;
      hcnt_q        <= hcnt_d;
      sync_sr_q     <= sync_sr_d;
      len_q         <= len_d;
      rem_q         <= rem_d;
      pk_q          <= pk_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: doc/qpsk_rx_framer.md
# qpsk_rx_framer

Receive-side controller for the QPSK demodulator. It generates the symbol-centre sampling strobe and consumes the 2-bit Gray-decoded symbols. It hunts for a 16-bit sync word, reads a one-byte length header, and delivers the payload as bytes on a valid/ready stream with frame status pulses. It sits between the demodulator and the packet/byte sink.

## Interface
- `SPS`, default 4: clock cycles per symbol; legal range 2..255.
- `SYNC_WORD`, default 16'hE4B1: sync pattern, 8 symbols. The first symbol occupies bits [15:14].
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: receiver enable. When low, the block is held idle.
- `demod_sym` in 2: demodulator symbol output, valid in the cycle after `sample_en`.
- `sample_en` out 1: one-cycle strobe marking the symbol-centre sample; the demodulator captures I/Q on this edge.
- `m_data` out 8: payload byte.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: sink accepts the byte.
- `m_last` out 1: the current byte is the final payload byte of the frame.
- `frame_start` out 1: one-cycle pulse on sync match.
- `frame_done` out 1: one-cycle pulse after the last payload byte is packed.
- `frame_err` out 1: one-cycle pulse on zero length or overrun.
- `busy` out 1: high in LEN or PAYLOAD.

## Operation
- **Strobe counter** `cnt` (8 bit):
  - Runs 0..SPS-1 while `en`=1 and wraps to 0.
  - `sample_en` is registered and is high in the cycle after `cnt`==SPS-1.
  - `en`=0 clears `cnt` and forces `sample_en` to 0.
- **Symbol take:** `take` = `sample_en` delayed one cycle. `demod_sym` is consumed only when `take`=1.
- **Bit order:** `demod_sym[1]` is the earlier bit. Bytes are packed MSB first, 4 symbols per byte, into shift register `pk` with a symbol counter `sc` (0..3).
- **States:**
  - **IDLE:** entered when `en`=0. `busy`=0.
  - **HUNT:**
    - On each take: `sync_sr` <= {`sync_sr`[13:0], `demod_sym`}, and `hcnt` increments, saturating at 8.
    - Match condition: (new `sync_sr`) == `SYNC_WORD` and (new `hcnt`) == 8.
    - On match: go to LEN, pulse `frame_start`, clear `sc`.
    - `hcnt` clears on every entry to HUNT, so a sync match needs 8 fresh symbols.
  - **LEN:**
    - Pack 4 symbols into `len`.
    - If the 4th symbol gives `len`==0: pulse `frame_err` and return to HUNT.
    - Otherwise load `rem`=`len` and go to PAYLOAD.
  - **PAYLOAD:**
    - On each 4th symbol (byte complete):
      - If the output slot is free (`m_valid`=0, or `m_valid`&&`m_ready` in the same cycle): load `m_data`, set `m_valid`, set `m_last`=(`rem`==1), and decrement `rem`.
      - If `rem` was 1: pulse `frame_done` and go to HUNT.
    - **Overrun** (slot occupied and not accepted this cycle):
      - Drop the new byte, pulse `frame_err`, go to HUNT.
      - The held byte stays valid and unchanged until accepted.
- **Output slot:** `m_valid` clears on `m_valid`&&`m_ready` unless a new byte loads in the same cycle; `m_data`/`m_last` are stable while `m_valid`&&!`m_ready`.
- **Enable:**
  - `en`=0 forces IDLE and clears `sc`, `hcnt`, `sync_sr` and `rem`. The output slot is not cleared and still completes its handshake.
  - `en` 0→1 enters HUNT.
  - `en` falling mid-frame gives no `frame_done` and no `frame_err`.
- **Reset:**
  - All outputs reset to 0 (`sample_en`, `m_data`, `m_valid`, `m_last`, `frame_start`, `frame_done`, `frame_err`, `busy`).
  - State resets to IDLE; `cnt`, `sc`, `hcnt`, `sync_sr`, `len`, `rem` reset to 0.
  - Reset mid-frame discards any held byte.

## Timing
- First `sample_en` comes SPS cycles after the first cycle with `en`=1, then every SPS cycles.
- Demodulator latency is 1 cycle, so symbol consumption happens at `sample_en`+1.
- `frame_start`, `frame_err` and `frame_done` are registered and high in the cycle after the deciding take. The state change takes effect in that same cycle.
- `m_valid` rises the cycle after the 4th take of a byte.
- Frame length: 8 + 4 + 4·`len` symbols; maximum payload 255 bytes.
- `busy` is high from the `frame_start` cycle until the cycle of `frame_done`/`frame_err`; it is low in that cycle.
- A sink with `m_ready` held at 1 never overruns, because the next byte arrives ≥4·SPS cycles later.

## Test plan
- **Reset/idle:** assert `rst` mid-count, then `en`=0 → all outputs 0; no `sample_en` while `en`=0.
- **Strobe period:** `en`=1, SPS=4 → `sample_en` at cycles 4, 8, 12 after enable, with width 1.
- **Nominal frame:**
  - Stimulus: `SYNC_WORD` E4B1, len=3, payload A5 3C FF, `m_ready`=1.
  - Required: `frame_start` once; bytes A5, 3C, FF with `m_last` only on FF; `frame_done` once; return to HUNT.
- **False/partial sync:**
  - 7 symbols of sync after enable, then full sync with preceding garbage → only the complete 8-fresh-symbol match pulses `frame_start`.
  - Stimulus E4B0 → no `frame_start`.
- **Zero length:** sync followed by len=00 → `frame_err` pulse, no `m_valid`, HUNT again; a following valid frame is received correctly.
- **Backpressure/overrun:**
  - `m_ready`=0 during a len=2 frame: byte 1 is held stable, byte 2 triggers `frame_err`, byte 1 is still delivered when `m_ready` rises, and there is no `frame_done`.
  - Repeat with `en` dropped mid-frame: no pulses, and the held byte still handshakes.
